// File: rtl/flex_stp_pkg.sv
// Shared types and parameter helpers for the flex_stp lane deserialiser.
package flex_stp_pkg;

  typedef enum logic {
    MODE_NARROW = 1'b0,
    MODE_WIDE   = 1'b1
  } lane_mode_e;

  function automatic int cnt_width(input int word_bits);
    return $clog2(word_bits + 1);
  endfunction

  function automatic bit params_legal(input int word_bits, input int lanes);
    return (lanes > 0) && ((word_bits % lanes) == 0);
  endfunction

endpackage

// File: rtl/flex_stp_bit_counter.sv
// Bit counter for flex_stp_lane_sr: advances by 1 or LANES per shift, wraps at WORD_BITS.
module flex_stp_bit_counter
  import flex_stp_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int LANES     = 4,
  parameter int CW        = cnt_width(WORD_BITS)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          shift_enable,
  input  lane_mode_e    mode,
  output logic [CW-1:0] count,
  output logic          complete
);

  localparam logic [CW-1:0] G_WIDE   = CW'(LANES);
  localparam logic [CW-1:0] G_NARROW = CW'(1);
  localparam logic [CW-1:0] WORD_CNT = CW'(WORD_BITS);

  logic [CW-1:0] count_q, count_d, count_next;

  always_comb begin
    count_next = count_q + ((mode == MODE_WIDE) ? G_WIDE : G_NARROW);
    complete   = shift_enable && !clear && (count_next == WORD_CNT);
    count_d    = count_q;
    if (clear)
      count_d = '0;
    else if (shift_enable)
      count_d = complete ? '0 : count_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/flex_stp_lane_sr.sv
// Multi-lane serial-to-parallel deserialiser with word framing and a one-word holding register.
// Define FLEX_STP_OVF_EN to build the sticky overflow flag; otherwise overflow is tied low.
module flex_stp_lane_sr
  import flex_stp_pkg::*;
#(
  parameter int WORD_BITS = 8,
  parameter int LANES     = 4,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 wide_mode,
  input  logic                 shift_enable,
  input  logic [LANES-1:0]     serial_in,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy,
  output logic                 overflow
);

  localparam int CW = cnt_width(WORD_BITS);

  if (!params_legal(WORD_BITS, LANES)) begin : g_bad_params
    $error("flex_stp_lane_sr: WORD_BITS must be a multiple of LANES");
  end

  logic [CW-1:0]        count;
  logic                 complete;
  lane_mode_e           mode_q, mode_d, mode_eff;
  logic [WORD_BITS-1:0] sr_q, sr_d, sr_shift;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic                 valid_q, valid_d;

  flex_stp_bit_counter #(
    .WORD_BITS (WORD_BITS),
    .LANES     (LANES),
    .CW        (CW)
  ) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .shift_enable (shift_enable),
    .mode         (mode_eff),
    .count        (count),
    .complete     (complete)
  );

  always_comb begin
    // Mode is sampled only when a word starts; mid-word changes wait for the next word.
    mode_eff = (count == '0) ? (wide_mode ? MODE_WIDE : MODE_NARROW) : mode_q;
    mode_d   = mode_q;
    if (clear)
      mode_d = MODE_NARROW;
    else if (shift_enable && (count == '0))
      mode_d = mode_eff;

    if (mode_eff == MODE_WIDE) begin
      if (SHIFT_MSB) sr_shift = (sr_q << LANES) | WORD_BITS'(serial_in);
      else           sr_shift = (sr_q >> LANES) | (WORD_BITS'(serial_in) << (WORD_BITS - LANES));
    end else begin
      if (SHIFT_MSB) sr_shift = (sr_q << 1) | WORD_BITS'(serial_in[0]);
      else           sr_shift = (sr_q >> 1) | (WORD_BITS'(serial_in[0]) << (WORD_BITS - 1));
    end

    sr_d    = sr_q;
    word_d  = word_q;
    valid_d = valid_q;
    if (clear) begin
      sr_d    = '1;
      valid_d = 1'b0;
    end else begin
      if (shift_enable)
        sr_d = complete ? '1 : sr_shift;
      if (complete) begin
        if (!valid_q || word_ready) begin
          word_d  = sr_shift;
          valid_d = 1'b1;
        end
      end else if (valid_q && word_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mode_q  <= MODE_NARROW;
      sr_q    <= '1;
      word_q  <= '1;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

`ifdef FLEX_STP_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = clear ? 1'b0 : (ovf_q | (complete && valid_q && !word_ready));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign busy       = (count != '0);

endmodule

// File: doc/flex_stp_lane_sr.md
# flex_stp_lane_sr

Parametrised multi-lane serial-to-parallel deserialiser with word framing and a one-word output buffer. Each enabled cycle it shifts 1 bit (narrow mode) or LANES bits (wide mode) into a WORD_BITS shift register. It counts the accumulated bits and hands each completed word to a valid/ready holding register. It sits behind the SD DAT-line samplers and feeds byte/word consumers such as the block FIFO and CRC checker.

## Interface
- WORD_BITS, 8, width of the assembled word; must be a multiple of LANES.
- LANES, 4, number of serial input lanes; one of 1, 2, 4, 8.
- SHIFT_MSB, 1, 1: new bits enter at LSB and shift toward MSB; 0: new bits enter at MSB and shift toward LSB.

- clk  input  1  rising-edge clock.
- n_rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; discards the partial word, the held word and the flags.
- wide_mode  input  1  0: 1 bit/shift on serial_in[0]; 1: LANES bits/shift.
- shift_enable  input  1  sample serial_in this cycle.
- serial_in  input  LANES  lane data; serial_in[LANES-1] is the most significant bit of each group.
- word_out  output  WORD_BITS  held word.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  consumer accepts word_out when word_valid=1.
- busy  output  1  partial word in progress (bit count ≠ 0).
- overflow  output  1  sticky; a completed word was dropped (macro-gated).

## Operation
- Shift register resets and clears to all ones, matching the SD idle-high level. Bit count resets to 0.
- Shift step with g = 1 (narrow) or LANES (wide), when SHIFT_MSB=1: sr ← {sr[WORD_BITS-1-g:0], in[g-1:0]}.
- Shift step when SHIFT_MSB=0: sr ← {in[g-1:0], sr[WORD_BITS-1:g]}.
- In narrow mode, in = serial_in[0]. In wide mode, in = serial_in.
- Mode is latched into mode_q on the first shift of each word (count==0 && shift_enable). It is ignored for the rest of that word; changing wide_mode mid-word has no effect until the next word.
- Counter width is $clog2(WORD_BITS+1). It increments by g per shift.
- When count+g == WORD_BITS, the shift completes the word, count wraps to 0, and sr returns to all ones.
- Word completion when the holding register is empty, or is being accepted this cycle: the completed word (including this shift's bits) loads into word_out, and word_valid=1.
- Word completion when the holding register is full and not accepted: the new word is discarded, word_out/word_valid are unchanged, and overflow is set.
- Acceptance (word_valid && word_ready) with no completion: word_valid←0. word_out holds its last value.
- Priority: n_rst > clear > shift/accept. clear sets sr to ones, count=0, word_valid=0, overflow=0.
- busy = (count ≠ 0), combinational from registers.

## Timing
- Reset values: word_out='1, word_valid=0, busy=0, overflow=0.
- Zero-latency framing: word_valid rises at the same clk edge that performs the completing shift.
- word_out is stable while word_valid=1 and word_ready=0.
- Back-to-back: a new word completing in the acceptance cycle keeps word_valid high with no bubble.
- Minimum word period is WORD_BITS/LANES cycles in wide mode and WORD_BITS cycles in narrow mode.
- shift_enable=0 freezes sr and count indefinitely.
- n_rst asserted mid-word discards the partial word. The next word starts cleanly at count 0.

## Configuration
- FLEX_STP_OVF_EN defined: the overflow register exists, behaving as specified above.
- FLEX_STP_OVF_EN undefined: overflow is tied to 0 and the register is removed. Dropped words are still discarded silently.

## Structure
- Package flex_stp_pkg holds:
  - the lane-mode typedef (MODE_NARROW, MODE_WIDE);
  - a function computing counter width from WORD_BITS;
  - a function checking the parameter legality rule (WORD_BITS % LANES == 0).
- Sub-module flex_stp_bit_counter holds the count register, the increment-by-g logic, wrap and the complete strobe. The top holds sr, mode_q, the holding register and the flags.

## Test plan
- Wide mode, WORD_BITS=8, LANES=4, SHIFT_MSB=1, word_ready=1: shift nibbles 0xA then 0x5 → word_out=0xA5, word_valid=1 for exactly 1 cycle, aligned with the 2nd shift edge.
- Narrow mode: shift bits 1,0,1,1,0,0,1,0 → word_out=0xB2 after the 8th edge; busy=1 during bits 1–7 and 0 after.
- Backpressure, word_ready=0: complete 0x12 then 0x34 → word_out stays 0x12 and overflow=1 (0 without FLEX_STP_OVF_EN). clear → word_valid=0, overflow=0.
- Simultaneous accept and complete: word_ready=1 on the edge where 0x56 completes while 0x34 is held → word_out=0x56, word_valid stays 1, no overflow.
- Reset mid-word: 4 narrow bits, then pulse n_rst → word_out=0xFF, busy=0. The next 8 bits 0xC3 produce exactly 0xC3.
- SHIFT_MSB=0, wide: nibbles 0xA then 0x5 → word_out=0x5A. Toggling wide_mode after the first nibble does not change the result.
